// File: rtl/bmem_line_arbiter.sv
// Arbitrates the single burst-memory port between I-cache line reads and D-cache reads/writebacks,
// converting lines to/from BURST_LEN-beat bursts. Define BMEM_ARB_RR_EN for round-robin grant.
module bmem_line_arbiter #(
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 64,
    parameter int  BURST_LEN = 4,
    localparam int LINE_W    = DATA_W * BURST_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [DATA_W-1:0] bmem_wdata,
    input  logic [DATA_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);
    localparam int OFS = $clog2(LINE_W / 8);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFS;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR_BURST, DONE} state_e;

    state_e            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              owner;          // 1 = D-cache owns the current burst
    logic [LINE_W-1:0] wline, rline, rline_d;
    logic              d_req, prefer_d, grant_d, grant_i;
    logic [ADDR_W-1:0] grant_addr;
`ifdef BMEM_ARB_RR_EN
    logic              last_owner;
`endif

    always_comb begin
        d_req = d_read | d_write;
`ifdef BMEM_ARB_RR_EN
        prefer_d = ~last_owner;
`else
        prefer_d = 1'b1;
`endif
        grant_d    = d_req && (!i_read || prefer_d);
        grant_i    = i_read && !grant_d;
        grant_addr = (grant_d ? d_addr : i_addr) & ALIGN_MASK;
        cnt_inc    = cnt + 1'b1;
        rline_d    = rline;
        rline_d[cnt*DATA_W +: DATA_W] = bmem_rdata;

        state_d = state;
        case (state)
            IDLE: begin
                // a simultaneous read+write from D is handled as a writeback
                if (grant_d && d_write)     state_d = WR_BURST;
                else if (grant_d || grant_i) state_d = RD_ISSUE;
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  if (bmem_resp && cnt == LAST) state_d = DONE;
            WR_BURST: if (cnt == LAST) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= 1'b0;
            wline      <= '0;
            rline      <= '0;
            i_rdata    <= '0;
            i_resp     <= 1'b0;
            d_rdata    <= '0;
            d_resp     <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
`ifdef BMEM_ARB_RR_EN
            last_owner <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            bmem_read  <= (state_d == RD_ISSUE);
            bmem_write <= (state_d == WR_BURST);
            i_resp     <= (state_d == DONE) && !owner;
            d_resp     <= (state_d == DONE) && owner;
            case (state)
                IDLE: begin
                    if (state_d != IDLE) begin
                        owner      <= grant_d;
                        wline      <= d_wdata;
                        cnt        <= '0;
                        bmem_addr  <= grant_addr;
                        bmem_wdata <= (state_d == WR_BURST) ? d_wdata[DATA_W-1:0] : '0;
`ifdef BMEM_ARB_RR_EN
                        last_owner <= grant_d;
`endif
                    end
                end
                RD_ISSUE: bmem_addr <= '0;
                RD_WAIT: begin
                    if (bmem_resp) begin
                        rline <= rline_d;
                        cnt   <= (cnt == LAST) ? '0 : cnt_inc;
                        if (cnt == LAST) begin
                            if (owner) d_rdata <= rline_d;
                            else       i_rdata <= rline_d;
                        end
                    end
                end
                WR_BURST: begin
                    // bmem_wdata already shows beat cnt; load the following beat
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        bmem_addr  <= '0;
                        bmem_wdata <= '0;
                    end else begin
                        cnt        <= cnt_inc;
                        bmem_wdata <= wline[cnt_inc*DATA_W +: DATA_W];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Directed and randomized bench for bmem_line_arbiter: a line-level reference model supplies
// expected addresses, beats, lines and grant order; a memory responder serves the read beats.
module tb_bmem_line_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int BL = 4;
    localparam int LW = DW * BL;
`ifdef BMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] i_addr, d_addr, bmem_addr;
    logic          i_read, d_read, d_write;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata;
    logic          i_resp, d_resp, bmem_read, bmem_write, bmem_resp;
    logic [DW-1:0] bmem_wdata, bmem_rdata;

    int pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
    int overlap_cnt = 0, illegal_cnt = 0, rd_cmd_cnt = 0, i_resp_cnt = 0, d_resp_cnt = 0;
    int exp_rd = 0;
    bit prev_d = 1'b0;
    logic [LW-1:0] i_line_exp = '0, d_line_exp = '0;
    logic [DW-1:0] exp_q[$];

    logic [LW-1:0] line, il, dl;
    logic [AW-1:0] ia, da;
    int kind, d_wr, w, ir0;
    bit first_d;

    bmem_line_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
        .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    // Counts the values seen during the cycle that this edge closes.
    always @(posedge clk) begin
        if (bmem_read && bmem_write) overlap_cnt++;
        if (d_read && d_write)       illegal_cnt++;
        if (bmem_read)               rd_cmd_cnt++;
        if (i_resp)                  i_resp_cnt++;
        if (d_resp)                  d_resp_cnt++;
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] line_base(input logic [AW-1:0] a);
        return a - (a % (LW / 8));
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l = '0;
        for (int k = 0; k < LW / 32; k++) l = {l[LW-33:0], 32'($urandom())};
        return l;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_bmem_read"},  bmem_read,  0);
        check({tag, "_bmem_write"}, bmem_write, 0);
        check({tag, "_bmem_addr"},  bmem_addr,  0);
        check({tag, "_bmem_wdata"}, bmem_wdata, 0);
        check({tag, "_i_resp"},     i_resp,     0);
        check({tag, "_d_resp"},     d_resp,     0);
        check({tag, "_i_rdata"},    i_rdata,    0);
        check({tag, "_d_rdata"},    d_rdata,    0);
    endtask

    task automatic raise(input bit is_d, input bit is_wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wl);
        if (!is_d) begin
            i_addr = addr;
            i_read = 1'b1;
        end else begin
            d_addr  = addr;
            d_wdata = wl;
            if (is_wr) d_write = 1'b1;
            else       d_read  = 1'b1;
        end
    endtask

    task automatic drop(input bit is_d);
        if (is_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
    endtask

    task automatic wait_issue(input bit is_wr, output int waited);
        waited = 0;
        while (((is_wr ? bmem_write : bmem_read) !== 1'b1) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic serve_read(input bit is_d, input logic [AW-1:0] addr, input logic [LW-1:0] l,
                              input int gap_mode);
        int waited, rd0, i0, d0, gap;
        int gaps_spec[4] = '{0, 2, 0, 1};
        wait_issue(1'b0, waited);
        check("rd_issue_lat", waited, 1);
        check("rd_addr", bmem_addr, line_base(addr));
        check("rd_no_write", bmem_write, 0);
        rd0 = rd_cmd_cnt;
        @(negedge clk);
        check("rd_pulse", bmem_read, 0);
        for (int k = 0; k < BL; k++) begin
            gap = (gap_mode == 1) ? gaps_spec[k] : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            repeat (gap) begin
                bmem_resp  = 1'b0;
                bmem_rdata = {$urandom(), $urandom()};
                @(negedge clk);
            end
            bmem_resp  = 1'b1;
            bmem_rdata = l[k*DW +: DW];
            @(negedge clk);
        end
        bmem_resp = 1'b0;
        i0 = i_resp_cnt;
        d0 = d_resp_cnt;
        if (is_d) d_line_exp = l;
        else      i_line_exp = l;
        check("rd_resp", is_d ? d_resp : i_resp, 1);
        check("rd_other_resp", is_d ? i_resp : d_resp, 0);
        check("rd_i_rdata", i_rdata, i_line_exp);
        check("rd_d_rdata", d_rdata, d_line_exp);
        drop(is_d);
        @(negedge clk);
        check("rd_resp_pulse", is_d ? d_resp : i_resp, 0);
        check("rd_resp_cnt", is_d ? d_resp_cnt - d0 : i_resp_cnt - i0, 1);
        check("rd_other_cnt", is_d ? i_resp_cnt - i0 : d_resp_cnt - d0, 0);
        check("rd_cmd_cnt", rd_cmd_cnt - rd0, 1);
        exp_rd++;
        prev_d = is_d;
    endtask

    task automatic serve_write(input logic [AW-1:0] addr, input logic [LW-1:0] l, input bit spurious);
        int waited, rd0, i0, d0;
        wait_issue(1'b1, waited);
        check("wr_issue_lat", waited, 1);
        rd0 = rd_cmd_cnt;
        for (int k = 0; k < BL; k++) exp_q.push_back(l[k*DW +: DW]);
        for (int k = 0; k < BL; k++) begin
            if (k > 0) @(negedge clk);
            check("wr_active", bmem_write, 1);
            check("wr_addr", bmem_addr, line_base(addr));
            check("wr_beat", bmem_wdata, exp_q.pop_front());
            check("wr_no_read", bmem_read, 0);
            if (spurious) begin
                bmem_resp  = 1'b1;
                bmem_rdata = {$urandom(), $urandom()};
            end
        end
        @(negedge clk);
        bmem_resp = 1'b0;
        i0 = i_resp_cnt;
        d0 = d_resp_cnt;
        check("wr_resp", d_resp, 1);
        check("wr_other_resp", i_resp, 0);
        check("wr_end", bmem_write, 0);
        check("wr_i_rdata", i_rdata, i_line_exp);
        check("wr_d_rdata", d_rdata, d_line_exp);
        drop(1'b1);
        @(negedge clk);
        check("wr_resp_pulse", d_resp, 0);
        check("wr_resp_cnt", d_resp_cnt - d0, 1);
        check("wr_other_cnt", i_resp_cnt - i0, 0);
        check("wr_no_rd_cmd", rd_cmd_cnt - rd0, 0);
        prev_d = 1'b1;
    endtask

    task automatic serve(input bit is_d, input bit is_wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] l, input int gap_mode, input bit spurious);
        if (is_wr) serve_write(addr, l, spurious);
        else       serve_read(is_d, addr, l, gap_mode);
    endtask

    initial begin
        rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; bmem_resp = 1'b0; bmem_rdata = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // I-cache read of a fixed line
        line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        raise(1'b0, 1'b0, 32'h6000_0044, '0);
        check("t1_aligned", line_base(32'h6000_0044), 32'h6000_0040);
        serve(1'b0, 1'b0, 32'h6000_0044, line, 0, 1'b0);

        // D-cache writeback of beats A,B,C,D
        line = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        raise(1'b1, 1'b1, 32'h6000_1000, line);
        serve(1'b1, 1'b1, 32'h6000_1000, line, 0, 1'b0);

        // Simultaneous reads; previous owner is D
        ia = 32'h1234_5678; da = 32'h8765_4321; il = rand_line(); dl = rand_line();
        raise(1'b0, 1'b0, ia, '0);
        raise(1'b1, 1'b0, da, '0);
        first_d = RR ? !prev_d : 1'b1;
        if (first_d) begin
            serve(1'b1, 1'b0, da, dl, 0, 1'b0);
            serve(1'b0, 1'b0, ia, il, 0, 1'b0);
        end else begin
            serve(1'b0, 1'b0, ia, il, 0, 1'b0);
            serve(1'b1, 1'b0, da, dl, 0, 1'b0);
        end

        // Read beats with gaps
        dl = rand_line();
        raise(1'b1, 1'b0, 32'h0000_0ABC, '0);
        serve(1'b1, 1'b0, 32'h0000_0ABC, dl, 1, 1'b0);

        // Spurious bmem_resp in IDLE, then during a writeback, then a clean read
        for (int k = 0; k < 3; k++) begin
            bmem_resp  = 1'b1;
            bmem_rdata = {$urandom(), $urandom()};
            @(negedge clk);
            check("idle_spur_read", bmem_read, 0);
            check("idle_spur_resp", {i_resp, d_resp}, 0);
            check("idle_spur_i_rdata", i_rdata, i_line_exp);
            check("idle_spur_d_rdata", d_rdata, d_line_exp);
        end
        bmem_resp = 1'b0;
        dl = rand_line();
        raise(1'b1, 1'b1, 32'h4000_0020, dl);
        serve(1'b1, 1'b1, 32'h4000_0020, dl, 0, 1'b1);
        il = rand_line();
        raise(1'b0, 1'b0, 32'h4000_0100, '0);
        serve(1'b0, 1'b0, 32'h4000_0100, il, 0, 1'b0);

        // Reset after two beats of a read
        il = rand_line();
        raise(1'b0, 1'b0, 32'h5000_0040, '0);
        wait_issue(1'b0, w);
        check("rst_issue_lat", w, 1);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bmem_resp  = 1'b1;
            bmem_rdata = il[k*DW +: DW];
            @(negedge clk);
        end
        bmem_resp = 1'b0;
        ir0 = i_resp_cnt;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        i_line_exp = '0; d_line_exp = '0; prev_d = 1'b0; exp_rd++;
        drop(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_no_resp", i_resp_cnt - ir0, 0);
        il = rand_line();
        raise(1'b0, 1'b0, 32'h5000_0040, '0);
        serve(1'b0, 1'b0, 32'h5000_0040, il, 2, 1'b0);

        // Randomized traffic against the grant-order model
        for (int t = 0; t < 10; t++) begin
            kind = $urandom_range(0, 2);
            d_wr = $urandom_range(0, 1);
            ia = $urandom(); da = $urandom(); il = rand_line(); dl = rand_line();
            if (kind != 1) raise(1'b0, 1'b0, ia, '0);
            if (kind != 0) raise(1'b1, d_wr[0], da, dl);
            first_d = (kind == 2) ? (RR ? !prev_d : 1'b1) : (kind == 1);
            if (kind == 0) begin
                serve(1'b0, 1'b0, ia, il, 2, 1'b0);
            end else if (kind == 1) begin
                serve(1'b1, d_wr[0], da, dl, 2, 1'b1);
            end else if (first_d) begin
                serve(1'b1, d_wr[0], da, dl, 2, 1'b1);
                serve(1'b0, 1'b0, ia, il, 2, 1'b0);
            end else begin
                serve(1'b0, 1'b0, ia, il, 2, 1'b0);
                serve(1'b1, d_wr[0], da, dl, 2, 1'b1);
            end
        end

        @(negedge clk);
        check("no_rd_wr_overlap", overlap_cnt, 0);
        check("no_illegal_req", illegal_cnt, 0);
        check("total_read_bursts", rd_cmd_cnt, exp_rd);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
